// File: rtl/hwag_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwag_sync_ctrl
// Brief    : HWAG tooth/gap acquisition FSM, tooth counter and sync strobes.
//            Optional macro HWAG_SYNC_LOSS_CNT_EN adds a saturating loss counter.
// Revision : 1.0
// ============================================================================
module hwag_sync_ctrl #(
    parameter int TCNT_WIDTH = 8,
    parameter int TOOTH_LOAD = 2,
    parameter int TOOTH_TOP  = 57,
    parameter int FILL_CNT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  meas_vld,
    input  logic                  gap_found,
    input  logic                  period_normal,
    input  logic                  pcnt_ovf,
    output logic                  cap_clr,
    output logic [2:0]            state,
    output logic                  sync,
    output logic [TCNT_WIDTH-1:0] tcnt,
    output logic                  tooth_stb,
    output logic                  rev_stb,
    output logic                  loss_stb,
    output logic [7:0]            loss_cnt
);

    localparam int FW = (FILL_CNT > 1) ? $clog2(FILL_CNT + 1) : 1;
    localparam logic [FW-1:0]         C_FILL_ONE = FW'(1);
    localparam logic [FW-1:0]         C_FILL_TOP = FW'(FILL_CNT);
    localparam logic                  C_SKIP_FILL = (FILL_CNT <= 1);
    localparam logic [TCNT_WIDTH-1:0] C_TLOAD = TCNT_WIDTH'(TOOTH_LOAD);
    localparam logic [TCNT_WIDTH-1:0] C_TTOP  = TCNT_WIDTH'(TOOTH_TOP);
    localparam logic [TCNT_WIDTH-1:0] C_TONE  = TCNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_VERIFY = 3'd3,
        ST_SYNC   = 3'd4
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [TCNT_WIDTH-1:0] r_tcnt_q, w_tcnt_d;
    logic [FW-1:0]         r_fill_q, w_fill_d;
    logic                  r_sync_q, w_sync_d;
    logic                  r_cap_clr_q, w_cap_clr_d;
    logic                  r_tooth_stb_q, w_tooth_stb_d;
    logic                  r_rev_stb_q, w_rev_stb_d;
    logic                  r_loss_stb_q, w_loss_stb_d;
    logic                  w_tracking;

    always_comb begin
        w_state_d     = r_state_q;
        w_tcnt_d      = r_tcnt_q;
        w_fill_d      = r_fill_q;
        w_cap_clr_d   = 1'b0;
        w_tooth_stb_d = 1'b0;
        w_rev_stb_d   = 1'b0;
        w_loss_stb_d  = 1'b0;
        w_tracking    = (r_state_q == ST_VERIFY) || (r_state_q == ST_SYNC);

        // A stall outranks any edge arriving in the same cycle
        if (pcnt_ovf && (r_state_q != ST_IDLE)) begin
            w_state_d    = ST_IDLE;
            w_tcnt_d     = '0;
            w_fill_d     = '0;
            w_cap_clr_d  = 1'b1;
            w_loss_stb_d = w_tracking;
        end else if (meas_vld) begin
            case (r_state_q)
                ST_IDLE: begin
                    w_fill_d  = C_FILL_ONE;
                    w_state_d = C_SKIP_FILL ? ST_SEARCH : ST_FILL;
                end
                ST_FILL: begin
                    w_fill_d = r_fill_q + C_FILL_ONE;
                    if (w_fill_d == C_FILL_TOP) begin
                        w_state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (gap_found && period_normal) begin
                        w_state_d     = ST_VERIFY;
                        w_tcnt_d      = C_TLOAD;
                        w_tooth_stb_d = 1'b1;
                    end
                end
                ST_VERIFY, ST_SYNC: begin
                    if ((r_tcnt_q != C_TTOP) && !gap_found && period_normal) begin
                        w_tcnt_d      = r_tcnt_q + C_TONE;
                        w_tooth_stb_d = 1'b1;
                    end else if ((r_tcnt_q == C_TTOP) && gap_found && period_normal) begin
                        w_tcnt_d      = C_TLOAD;
                        w_tooth_stb_d = 1'b1;
                        w_rev_stb_d   = (r_state_q == ST_SYNC);
                        w_state_d     = ST_SYNC;
                    end else begin
                        w_state_d    = ST_SEARCH;
                        w_tcnt_d     = '0;
                        w_loss_stb_d = 1'b1;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_tcnt_d  = '0;
                    w_fill_d  = '0;
                end
            endcase
        end

        w_sync_d = (w_state_d == ST_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_tcnt_q      <= '0;
            r_fill_q      <= '0;
            r_sync_q      <= 1'b0;
            r_cap_clr_q   <= 1'b0;
            r_tooth_stb_q <= 1'b0;
            r_rev_stb_q   <= 1'b0;
            r_loss_stb_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_tcnt_q      <= w_tcnt_d;
            r_fill_q      <= w_fill_d;
            r_sync_q      <= w_sync_d;
            r_cap_clr_q   <= w_cap_clr_d;
            r_tooth_stb_q <= w_tooth_stb_d;
            r_rev_stb_q   <= w_rev_stb_d;
            r_loss_stb_q  <= w_loss_stb_d;
        end
    end

`ifdef HWAG_SYNC_LOSS_CNT_EN
    logic [7:0] r_loss_cnt_q, w_loss_cnt_d;

    always_comb begin
        w_loss_cnt_d = r_loss_cnt_q;
        if (w_loss_stb_d && (r_loss_cnt_q != 8'hFF)) begin
            w_loss_cnt_d = r_loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt_q <= 8'd0;
        end else begin
            r_loss_cnt_q <= w_loss_cnt_d;
        end
    end

    assign loss_cnt = r_loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign state     = r_state_q;
    assign sync      = r_sync_q;
    assign tcnt      = r_tcnt_q;
    assign cap_clr   = r_cap_clr_q;
    assign tooth_stb = r_tooth_stb_q;
    assign rev_stb   = r_rev_stb_q;
    assign loss_stb  = r_loss_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_hwag_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_sync_ctrl
// Brief    : Directed + randomized bench for hwag_sync_ctrl with a reference
//            model of the acquisition rules.
// Revision : 1.0
// ============================================================================
module tb_hwag_sync_ctrl;

    localparam int TW    = 8;
    localparam int TLOAD = 2;
    localparam int TTOP  = 57;
    localparam int FILLN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          meas_vld = 1'b0;
    logic          gap_found = 1'b0;
    logic          period_normal = 1'b0;
    logic          pcnt_ovf = 1'b0;
    logic          cap_clr;
    logic [2:0]    state;
    logic          sync;
    logic [TW-1:0] tcnt;
    logic          tooth_stb;
    logic          rev_stb;
    logic          loss_stb;
    logic [7:0]    loss_cnt;

    hwag_sync_ctrl #(
        .TCNT_WIDTH (TW),
        .TOOTH_LOAD (TLOAD),
        .TOOTH_TOP  (TTOP),
        .FILL_CNT   (FILLN)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .meas_vld      (meas_vld),
        .gap_found     (gap_found),
        .period_normal (period_normal),
        .pcnt_ovf      (pcnt_ovf),
        .cap_clr       (cap_clr),
        .state         (state),
        .sync          (sync),
        .tcnt          (tcnt),
        .tooth_stb     (tooth_stb),
        .rev_stb       (rev_stb),
        .loss_stb      (loss_stb),
        .loss_cnt      (loss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0..4 = idle, fill, search, verify, sync
    int m_mode   = 0;
    int m_tooth  = 0;
    int m_fill   = 0;
    int m_losses = 0;
    int n_teeth  = 0;
    int n_revs   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit mv, input bit gf, input bit pn, input bit ovf);
        bit e_tooth, e_rev, e_loss, e_cap;
        bit want_gap;
        rst = rs; meas_vld = mv; gap_found = gf; period_normal = pn; pcnt_ovf = ovf;
        @(posedge clk);
        #1;
        e_tooth = 0; e_rev = 0; e_loss = 0; e_cap = 0;
        if (rs) begin
            m_mode = 0; m_tooth = 0; m_fill = 0; m_losses = 0;
        end else if (ovf && m_mode != 0) begin
            e_loss = (m_mode >= 3);
            e_cap  = 1;
            m_mode = 0; m_tooth = 0; m_fill = 0;
        end else if (mv) begin
            if (m_mode == 0) begin
                m_fill = 1;
                m_mode = (m_fill >= FILLN) ? 2 : 1;
            end else if (m_mode == 1) begin
                m_fill = m_fill + 1;
                if (m_fill >= FILLN) m_mode = 2;
            end else if (m_mode == 2) begin
                if (gf && pn) begin
                    m_mode = 3; m_tooth = TLOAD; e_tooth = 1;
                end
            end else begin
                // The gap is due exactly after the last tooth; anything else is a loss
                want_gap = (m_tooth == TTOP);
                if (pn && (gf == want_gap)) begin
                    e_tooth = 1;
                    if (want_gap) begin
                        e_rev   = (m_mode == 4);
                        m_mode  = 4;
                        m_tooth = TLOAD;
                    end else begin
                        m_tooth = m_tooth + 1;
                    end
                end else begin
                    e_loss  = 1;
                    m_mode  = 2;
                    m_tooth = 0;
                end
            end
        end
`ifdef HWAG_SYNC_LOSS_CNT_EN
        if (e_loss && m_losses < 255) m_losses = m_losses + 1;
`endif
        if (tooth_stb) n_teeth++;
        if (rev_stb) n_revs++;
        check_val("state",     32'(state),     32'(m_mode));
        check_val("sync",      32'(sync),      32'(m_mode == 4));
        check_val("tcnt",      32'(tcnt),      32'(m_tooth));
        check_val("tooth_stb", 32'(tooth_stb), 32'(e_tooth));
        check_val("rev_stb",   32'(rev_stb),   32'(e_rev));
        check_val("loss_stb",  32'(loss_stb),  32'(e_loss));
        check_val("cap_clr",   32'(cap_clr),   32'(e_cap));
        check_val("loss_cnt",  32'(loss_cnt),  32'(m_losses));
    endtask

    task automatic tooth_edge(input bit gf, input bit pn);
        step(0, 1, gf, pn, 0);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic normal_teeth(input int n);
        for (int i = 0; i < n; i++) begin
            tooth_edge(0, 1);
            if ($urandom_range(0, 1) == 1) quiet(1);
        end
    endtask

    task automatic reach_sync;
        tooth_edge(1, 1);
        normal_teeth(TTOP - TLOAD);
        tooth_edge(1, 1);
    endtask

    initial begin
        bit rs, mv, gf, pn, ovf;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        quiet(2);

        // Fill phase discards three edges, even ones carrying a gap verdict
        tooth_edge(0, 1); quiet(1);
        tooth_edge(1, 1); quiet(1);
        tooth_edge(0, 1);
        check_val("fill_to_search", 32'(state), 32'd2);

        // First gap enters VERIFY, next gap confirms SYNC without rev_stb
        tooth_edge(1, 1);
        check_val("verify_load", 32'(tcnt), 32'(TLOAD));
        normal_teeth(TTOP - TLOAD);
        check_val("verify_top", 32'(tcnt), 32'(TTOP));
        n_revs = 0;
        tooth_edge(1, 1);
        check_val("sync_entry", 32'(sync), 32'd1);
        check_val("no_rev_on_entry", 32'(n_revs), 32'd0);

        // One full revolution in SYNC: 56 teeth, one rev strobe on the gap
        n_teeth = 0;
        normal_teeth(TTOP - TLOAD);
        tooth_edge(1, 1);
        check_val("teeth_per_rev", 32'(n_teeth), 32'(TTOP - TLOAD + 1));
        check_val("first_rev", 32'(n_revs), 32'd1);

        // Missing gap at the top tooth
        normal_teeth(TTOP - TLOAD);
        tooth_edge(0, 1);
        check_val("missing_gap_loss", 32'(loss_stb), 32'd1);

        // Early gap at tooth 30, then the very next good gap restarts VERIFY
        reach_sync();
        normal_teeth(30 - TLOAD);
        check_val("at_tooth_30", 32'(tcnt), 32'd30);
        tooth_edge(1, 1);
        check_val("early_gap_loss", 32'(state), 32'd2);
        tooth_edge(1, 1);
        check_val("reverify_load", 32'(tcnt), 32'(TLOAD));

        // Stall and gap edge together while synced
        normal_teeth(TTOP - TLOAD);
        tooth_edge(1, 1);
        normal_teeth(5);
        step(0, 1, 1, 1, 1);
        check_val("ovf_wins", 32'(state), 32'd0);
        step(0, 0, 0, 0, 1);
        quiet(2);

        // Randomized wheel with injected faults, stalls and resets
        for (int i = 0; i < 6000; i++) begin
            rs  = ($urandom_range(0, 1999) == 0);
            mv  = ($urandom_range(0, 2) != 0);
            ovf = ($urandom_range(0, 499) == 0);
            pn  = ($urandom_range(0, 79) != 0);
            if (m_mode >= 3) gf = (m_tooth == TTOP);
            else             gf = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) gf = ~gf;
            step(rs, mv, gf, pn, ovf);
        end

        // Forced losses for counter saturation
        step(1, 0, 0, 0, 0);
        tooth_edge(0, 1); tooth_edge(0, 1); tooth_edge(0, 1);
        for (int i = 0; i < 300; i++) begin
            tooth_edge(1, 1);
            tooth_edge(0, 0);
        end
`ifdef HWAG_SYNC_LOSS_CNT_EN
        check_val("loss_cnt_sat", 32'(loss_cnt), 32'd255);
`else
        check_val("loss_cnt_off", 32'(loss_cnt), 32'd0);
`endif

        step(1, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
